uart_tx_stage: RTL and testbench
================================

UART_TX_STAGE -- requirements
Module: uart_tx_stage

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: frame payload bits, matching the feeding FIFO word width.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit, legal range 2..65535.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port fifo_dout  input  DATA_WIDTH  head word of the upstream FIFO, valid whenever fifo_empty is low.
REQ-006 The block SHALL have port fifo_empty  input  1  upstream FIFO holds no word.
REQ-007 The block SHALL have port fifo_rd_en  output  1  pop strobe to the upstream FIFO.
REQ-008 The block SHALL have port tx  output  1  serial line, idle high.
REQ-009 The block SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 The block SHALL have port frame_done  output  1  one-cycle pulse at the end of each frame.

Function
REQ-011 The block SHALL implement states IDLE, START, DATA and STOP, with state, tx, busy and frame_done registered.
REQ-012 fifo_rd_en SHALL be combinational: (state==IDLE) && !fifo_empty && !rst; this is the only pop source.
- Exactly one pop per frame.
- Never asserted while fifo_empty is high.
REQ-013 On an edge where fifo_rd_en is high, the block SHALL:
- latch fifo_dout into the shift register;
- move to START;
- drive tx low;
- clear the baud counter.
REQ-014 The block SHALL hold each bit for exactly CLKS_PER_BIT cycles.
- The baud counter counts 0..CLKS_PER_BIT-1.
- The state or bit advances on the edge where the counter equals CLKS_PER_BIT-1; the counter then wraps to 0.
REQ-015 START SHALL drive tx=0 for one bit time, then go to DATA with bit index 0.
REQ-016 DATA SHALL send payload LSB first.
- tx = shift_reg[0]; the register shifts right at each bit boundary.
- After bit index DATA_WIDTH-1 completes, the state goes to STOP.
- The bit index is sized ceil(log2(DATA_WIDTH)) and never wraps mid-frame.
REQ-017 STOP SHALL drive tx=1 for one bit time; at its final cycle boundary the block SHALL go to IDLE and assert frame_done for the following single cycle.
REQ-018 IDLE SHALL drive tx=1 and last at least one cycle, so back-to-back frames are separated by exactly one clock of idle-high.
REQ-019 Total frame length SHALL be (DATA_WIDTH+2)*CLKS_PER_BIT cycles from the tx falling edge to re-entry into IDLE.
REQ-020 Changes on fifo_dout or fifo_empty outside IDLE SHALL have no effect on the frame in progress.
REQ-021 A simultaneous upstream write while fifo_empty is high SHALL NOT trigger a pop in that cycle; the pop occurs on the first cycle fifo_empty is observed low in IDLE.

Reset
REQ-022 While rst is high at a rising edge, the block SHALL reset to:
- state IDLE, tx=1, busy=0, frame_done=0;
- baud counter, bit index and shift register all 0;
- fifo_rd_en=0 for the whole reset cycle.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no stop bit and no frame_done, and SHALL NOT pop the FIFO.
REQ-024 On the first post-reset cycle with fifo_empty low, a new frame SHALL start from START.

Verification (CLKS_PER_BIT=4, DATA_WIDTH=8)
REQ-025 Reset with fifo_empty=0 and fifo_dout=0xFF -> fifo_rd_en=0 and tx=1 throughout reset; first pop on the first cycle after rst falls.
REQ-026 Single word 0xA5:
- one fifo_rd_en pulse;
- tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles);
- frame_done pulses once, 1 cycle after the stop bit ends;
- busy high for exactly 40 cycles.
REQ-027 FIFO preloaded with 0x00,0xFF,0x3C -> three pops spaced 41 cycles apart; tx decodes to 0x00,0xFF,0x3C; one idle-high cycle between frames.
REQ-028 fifo_empty held high for 100 cycles -> fifo_rd_en never asserted, tx=1, busy=0.
REQ-029 rst asserted at cycle 15 of a 0x55 frame -> tx=1 the next cycle, no frame_done, no extra pop; next word transmits cleanly afterwards.
REQ-030 fifo_dout changed during the DATA state of 0x81 -> serialized bits still equal 0x81.

Source files
------------

// File: rtl/uart_tx_stage.sv
// UART transmitter stage: pops one word per frame from an upstream FIFO and
// serializes it as start bit, DATA_WIDTH payload bits (LSB first), stop bit.
module uart_tx_stage #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0]   shreg_shift;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    bit_end;

    assign bit_end     = (cnt_q == CNT_LAST);
    assign shreg_shift = shreg_q >> 1;

    // Pop only from IDLE so that the FIFO sees exactly one strobe per frame.
    assign fifo_rd_en = (state_q == IDLE) && !fifo_empty && !rst;

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (fifo_rd_en) begin
                    shreg_d = fifo_dout;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                    tx_d    = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // tx is registered, so it takes the bit that becomes the new LSB.
                        shreg_d = shreg_shift;
                        idx_d   = idx_q + 1'b1;
                        tx_d    = shreg_shift[0];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_stage.sv
// Bench for uart_tx_stage: queue-backed FIFO, frame-level reference model checked
// every cycle, plus literal expectations for the directed frames.
module tb_uart_tx_stage;

    localparam int DW   = 8;
    localparam int CPB  = 4;
    localparam int FLEN = (DW + 2) * CPB;
    localparam int HN   = 8192;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic [DW-1:0] fifo_dout  = 8'hFF;
    logic          fifo_empty = 1'b0;
    logic          fifo_rd_en;
    logic          tx;
    logic          busy;
    logic          frame_done;

    always #5 clk = ~clk;

    uart_tx_stage #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] q[$];
    bit            rst_req  = 1'b1;
    bit            scramble = 1'b0;
    int            cyc      = 0;

    // Reference model: a frame is a 10-bit word {stop, data, start} held CPB cycles per bit.
    bit              m_active = 1'b0;
    bit              m_done   = 1'b0;
    int              m_t      = 0;
    logic [DW+1:0]   m_frame  = '1;

    int   rd_log[$];
    int   done_log[$];
    int   busy_cnt = 0;
    logic tx_hist[HN];

    int A5_SEQ[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        logic          exp_rd;
        logic          act_rd;
        logic [DW-1:0] cap;
        @(negedge clk);
        rst = rst_req;
        if (m_active && scramble) begin
            fifo_empty = 1'($urandom_range(0, 1));
            fifo_dout  = DW'($urandom);
        end else begin
            fifo_empty = (q.size() == 0);
            fifo_dout  = (q.size() > 0) ? q[0] : DW'($urandom);
        end
        #1;
        exp_rd = !m_active && !fifo_empty && !rst;
        chk("fifo_rd_en", {31'b0, fifo_rd_en}, {31'b0, exp_rd});
        chk("tx", {31'b0, tx}, {31'b0, (m_active ? m_frame[m_t / CPB] : 1'b1)});
        chk("busy", {31'b0, busy}, {31'b0, m_active});
        chk("frame_done", {31'b0, frame_done}, {31'b0, m_done});
        act_rd = fifo_rd_en;
        if (act_rd === 1'b1) rd_log.push_back(cyc);
        if (frame_done === 1'b1) done_log.push_back(cyc);
        if (busy === 1'b1) busy_cnt++;
        tx_hist[cyc % HN] = tx;
        cap = fifo_dout;
        @(posedge clk);
        if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_t      = 0;
        end else if (exp_rd) begin
            m_active = 1'b1;
            m_t      = 0;
            m_frame  = {1'b1, cap, 1'b0};
            m_done   = 1'b0;
        end else if (m_active) begin
            m_t++;
            m_done = 1'b0;
            if (m_t == FLEN) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end else begin
            m_done = 1'b0;
        end
        if (act_rd === 1'b1 && q.size() > 0) void'(q.pop_front());
        cyc++;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_active || m_done || q.size() > 0) && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) begin
            n_total++;
            $display("FAIL drain_timeout at cycle %0d: still busy after %0d cycles, expected idle", cyc, n);
        end
    endtask

    task automatic clear_logs();
        rd_log.delete();
        done_log.delete();
        busy_cnt = 0;
    endtask

    function automatic logic [DW-1:0] decode(input int c);
        logic [DW-1:0] d;
        for (int i = 0; i < DW; i++)
            d[i] = tx_hist[(c + 1 + CPB * (i + 1) + CPB / 2) % HN];
        return d;
    endfunction

    function automatic int rd_at(input int i);
        return (rd_log.size() > i) ? rd_log[i] : -1000;
    endfunction

    initial begin
        // Reset held with a non-empty FIFO showing 0xFF.
        q.push_back(8'hFF);
        rst_req = 1'b1;
        repeat (3) step();
        chk("reset_no_pop", rd_log.size(), 0);
        rst_req = 1'b0;
        step();
        chk("first_pop_after_reset", rd_at(0), cyc - 1);
        wait_idle();
        chk("decode_FF", {24'b0, decode(rd_at(0))}, 32'hFF);

        // Single 0xA5 frame.
        clear_logs();
        q.push_back(8'hA5);
        wait_idle();
        repeat (2) step();
        chk("a5_pops", rd_log.size(), 1);
        chk("a5_busy_cycles", busy_cnt, 40);
        chk("a5_done_count", done_log.size(), 1);
        chk("a5_done_offset", ((done_log.size() > 0) ? done_log[0] : -1000) - rd_at(0), 41);
        for (int k = 0; k < 10; k++)
            for (int j = 0; j < CPB; j++)
                chk("a5_bit", {31'b0, tx_hist[(rd_at(0) + 1 + CPB * k + j) % HN]}, A5_SEQ[k]);

        // Three back-to-back words.
        clear_logs();
        q.push_back(8'h00);
        q.push_back(8'hFF);
        q.push_back(8'h3C);
        wait_idle();
        chk("b2b_pops", rd_log.size(), 3);
        chk("b2b_spacing1", rd_at(1) - rd_at(0), 41);
        chk("b2b_spacing2", rd_at(2) - rd_at(1), 41);
        chk("b2b_word0", {24'b0, decode(rd_at(0))}, 32'h00);
        chk("b2b_word1", {24'b0, decode(rd_at(1))}, 32'hFF);
        chk("b2b_word2", {24'b0, decode(rd_at(2))}, 32'h3C);
        chk("b2b_idle_gap", {31'b0, tx_hist[rd_at(1) % HN]}, 1);
        chk("b2b_done_count", done_log.size(), 3);
        chk("b2b_busy_cycles", busy_cnt, 120);

        // Empty FIFO for 100 cycles.
        clear_logs();
        repeat (100) step();
        chk("empty_no_pop", rd_log.size(), 0);
        chk("empty_not_busy", busy_cnt, 0);
        chk("empty_no_done", done_log.size(), 0);

        // Reset at frame cycle 15 of 0x55 with a second word waiting.
        clear_logs();
        q.push_back(8'h55);
        q.push_back(8'h96);
        step();
        repeat (14) step();
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        chk("abort_single_pop", rd_log.size(), 1);
        step();
        chk("abort_tx_high", {31'b0, tx_hist[(cyc - 1) % HN]}, 1);
        wait_idle();
        chk("abort_total_pops", rd_log.size(), 2);
        chk("abort_done_count", done_log.size(), 1);
        chk("abort_next_word", {24'b0, decode(rd_at(1))}, 32'h96);

        // fifo_dout/fifo_empty scrambled while the 0x81 frame is in flight.
        clear_logs();
        scramble = 1'b1;
        q.push_back(8'h81);
        wait_idle();
        scramble = 1'b0;
        chk("scramble_pops", rd_log.size(), 1);
        chk("scramble_word", {24'b0, decode(rd_at(0))}, 32'h81);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0 && q.size() < 4) q.push_back(DW'($urandom));
            rst_req  = ($urandom_range(0, 199) == 0);
            scramble = 1'($urandom_range(0, 1));
            step();
        end
        rst_req  = 1'b0;
        scramble = 1'b0;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
